change_dispenser: RTL and testbench

//  Downstream of the vending controller: takes a change amount in cents and pays it
//  out through a coin hopper. Largest coin first (25/10/5), one coin per hopper

---
 rtl/change_pkg.sv | 24 ++
 rtl/change_coin_select.sv | 28 ++
 rtl/change_dispenser.sv | 165 ++++++++++++++++
 tb/tb_change_dispenser.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/change_pkg.sv
// Shared coin values, one-hot coin select and FSM state encoding for change_dispenser.
package change_pkg;

  localparam int unsigned QUARTER_CENTS = 25;
  localparam int unsigned DIME_CENTS    = 10;
  localparam int unsigned NICKEL_CENTS  = 5;

  // Bit order {quarter, dime, nickel} matches the hopper eject lines and inv_empty.
  typedef enum logic [2:0] {
    COIN_NONE    = 3'b000,
    COIN_NICKEL  = 3'b001,
    COIN_DIME    = 3'b010,
    COIN_QUARTER = 3'b100
  } coin_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EJECT,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } state_e;

endpackage

// File: rtl/change_coin_select.sv
// Combinational greedy coin chooser: largest available coin not exceeding the amount owed.
module change_coin_select
  import change_pkg::*;
#(
  parameter int VALUE_W = 7
) (
  input  logic [VALUE_W-1:0] rem_i,
  input  logic [2:0]         avail_i,
  output logic [2:0]         coin_o,
  output logic [VALUE_W-1:0] value_o
);

  always_comb begin
    coin_o  = COIN_NONE;
    value_o = '0;
    if (avail_i[2] && (rem_i >= VALUE_W'(QUARTER_CENTS))) begin
      coin_o  = COIN_QUARTER;
      value_o = VALUE_W'(QUARTER_CENTS);
    end else if (avail_i[1] && (rem_i >= VALUE_W'(DIME_CENTS))) begin
      coin_o  = COIN_DIME;
      value_o = VALUE_W'(DIME_CENTS);
    end else if (avail_i[0] && (rem_i >= VALUE_W'(NICKEL_CENTS))) begin
      coin_o  = COIN_NICKEL;
      value_o = VALUE_W'(NICKEL_CENTS);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount through a coin hopper, one coin per ack, largest coin first.
// Optional per-coin inventory tracking is enabled by defining CHANGE_INVENTORY_EN.
module change_dispenser
  import change_pkg::*;
#(
  parameter int VALUE_W     = 7,
  parameter int ACK_TIMEOUT = 16,
  parameter int INIT_COUNT  = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [VALUE_W-1:0] req_amount,
  output logic               eject_quarter,
  output logic               eject_dime,
  output logic               eject_nickel,
  input  logic               hopper_ack,
  input  logic               fault_clr,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [VALUE_W-1:0] remaining
`ifdef CHANGE_INVENTORY_EN
  ,
  output logic [2:0]         inv_empty
`endif
);

  localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);

  state_e               state_q, state_d;
  coin_e                coin_q, coin_d;
  logic [VALUE_W-1:0]   coin_val_q, coin_val_d;
  logic [VALUE_W-1:0]   rem_q, rem_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;

  logic [2:0]           avail;
  logic [VALUE_W-1:0]   sel_rem;
  logic [2:0]           sel_coin;
  logic [VALUE_W-1:0]   sel_value;
  logic [VALUE_W-1:0]   rem_after;
  logic [2:0]           eject_vec;

  // In IDLE the coin is picked from the incoming amount so EJECT can start next cycle.
  assign sel_rem = (state_q == ST_IDLE) ? req_amount : rem_q;

  change_coin_select #(
    .VALUE_W (VALUE_W)
  ) u_select (
    .rem_i   (sel_rem),
    .avail_i (avail),
    .coin_o  (sel_coin),
    .value_o (sel_value)
  );

  assign rem_after = rem_q - coin_val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      coin_q     <= COIN_NONE;
      coin_val_q <= '0;
      rem_q      <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      coin_q     <= coin_d;
      coin_val_q <= coin_val_d;
      rem_q      <= rem_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    coin_d     = coin_q;
    coin_val_d = coin_val_q;
    rem_d      = rem_q;
    timer_d    = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rem_d = req_amount;
          if (req_amount == '0) begin
            state_d = ST_DONE;
          end else if ((req_amount % VALUE_W'(NICKEL_CENTS)) != '0) begin
            state_d = ST_FAULT;
          end else if (sel_coin == COIN_NONE) begin
            state_d = ST_FAULT;
          end else begin
            state_d    = ST_EJECT;
            coin_d     = coin_e'(sel_coin);
            coin_val_d = sel_value;
            timer_d    = '0;
          end
        end
      end
      ST_EJECT: begin
        if (hopper_ack) begin
          rem_d   = rem_after;
          state_d = (rem_after == '0) ? ST_DONE : ST_GAP;
        end else if (timer_q == TIMER_W'(ACK_TIMEOUT - 1)) begin
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_GAP: begin
        // Reselect here so a coin exhausted by the previous ack is skipped.
        if (sel_coin == COIN_NONE) begin
          state_d = ST_FAULT;
        end else begin
          state_d    = ST_EJECT;
          coin_d     = coin_e'(sel_coin);
          coin_val_d = sel_value;
          timer_d    = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign eject_vec     = (state_q == ST_EJECT) ? coin_q : 3'b000;
  assign eject_quarter = eject_vec[2];
  assign eject_dime    = eject_vec[1];
  assign eject_nickel  = eject_vec[0];
  assign req_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q == ST_EJECT) || (state_q == ST_GAP);
  assign done          = (state_q == ST_DONE);
  assign fault         = (state_q == ST_FAULT);
  assign remaining     = rem_q;

`ifdef CHANGE_INVENTORY_EN
  logic [7:0] cnt_q [3];

  // Counts only move on an accepted coin; selection never picks an empty slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= 8'(INIT_COUNT);
    end else if ((state_q == ST_EJECT) && hopper_ack) begin
      for (int i = 0; i < 3; i++) begin
        if (coin_q[i]) cnt_q[i] <= cnt_q[i] - 8'd1;
      end
    end
  end

  assign avail     = {cnt_q[2] != 8'd0, cnt_q[1] != 8'd0, cnt_q[0] != 8'd0};
  assign inv_empty = ~avail;
`else
  assign avail = 3'b111;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; inventory scenario runs with CHANGE_INVENTORY_EN.
module tb_change_dispenser;

  localparam int VALUE_W = 7;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [VALUE_W-1:0] req_amount;
  logic               eject_quarter;
  logic               eject_dime;
  logic               eject_nickel;
  logic               hopper_ack;
  logic               fault_clr;
  logic               busy;
  logic               done;
  logic               fault;
  logic [VALUE_W-1:0] remaining;
`ifdef CHANGE_INVENTORY_EN
  logic [2:0]         inv_empty;
`endif

  int vectors;
  int miscompares;

  logic [2:0] ejects;
  assign ejects = {eject_quarter, eject_dime, eject_nickel};

  change_dispenser #(
    .VALUE_W     (VALUE_W),
    .ACK_TIMEOUT (16),
    .INIT_COUNT  (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_amount    (req_amount),
    .eject_quarter (eject_quarter),
    .eject_dime    (eject_dime),
    .eject_nickel  (eject_nickel),
    .hopper_ack    (hopper_ack),
    .fault_clr     (fault_clr),
    .busy          (busy),
    .done          (done),
    .fault         (fault),
    .remaining     (remaining)
`ifdef CHANGE_INVENTORY_EN
    ,
    .inv_empty     (inv_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyReset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_amount = '0;
    hopper_ack = 1'b0;
    fault_clr  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Presents a request for one cycle; returns in the cycle after the accepting edge.
  task automatic applyStimulus(input logic [VALUE_W-1:0] amount);
    req_valid  = 1'b1;
    req_amount = amount;
    tick();
    req_valid  = 1'b0;
    req_amount = '0;
  endtask

  // Entered in an EJECT cycle; acks in the second eject cycle, returns just after the ack edge.
  task automatic payCoin(input string tag, input logic [2:0] expEject, input logic [VALUE_W-1:0] remAfter);
    checkOutput({tag, "_eject"}, 32'(ejects), 32'(expEject));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    hopper_ack = 1'b1;
    tick();
    hopper_ack = 1'b0;
    checkOutput({tag, "_drop"}, 32'(ejects), 32'd0);
    checkOutput({tag, "_rem"}, 32'(remaining), 32'(remAfter));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_amount  = '0;
    hopper_ack  = 1'b0;
    fault_clr   = 1'b0;
    #3;
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_eject", 32'(ejects), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_rem", 32'(remaining), 32'd0);
`ifdef CHANGE_INVENTORY_EN
    checkOutput("rst_inv", 32'(inv_empty), 32'd0);
`endif

    $display("[TB] scenario 1: 35 cents");
    applyReset();
    applyStimulus(7'd35);
    checkOutput("s1_ready", 32'(req_ready), 32'd0);
    checkOutput("s1_rem0", 32'(remaining), 32'd35);
    payCoin("s1_q", 3'b100, 7'd10);
    checkOutput("s1_gap_busy", 32'(busy), 32'd1);
    tick();
    payCoin("s1_d", 3'b010, 7'd0);
    checkOutput("s1_done", 32'(done), 32'd1);
    tick();
    checkOutput("s1_done_once", 32'(done), 32'd0);
    checkOutput("s1_ready_back", 32'(req_ready), 32'd1);
    checkOutput("s1_idle_busy", 32'(busy), 32'd0);

    $display("[TB] scenario 2: 40 cents with gaps");
    applyReset();
    applyStimulus(7'd40);
    payCoin("s2_q", 3'b100, 7'd15);
    hopper_ack = 1'b1;
    tick();
    hopper_ack = 1'b0;
    checkOutput("s2_gap_ack_ignored", 32'(remaining), 32'd15);
    payCoin("s2_d", 3'b010, 7'd5);
    tick();
    payCoin("s2_n", 3'b001, 7'd0);
    checkOutput("s2_done", 32'(done), 32'd1);
    tick();
    checkOutput("s2_ready", 32'(req_ready), 32'd1);

    $display("[TB] scenario 3: zero amount");
    applyReset();
    applyStimulus(7'd0);
    checkOutput("s3_done", 32'(done), 32'd1);
    checkOutput("s3_eject", 32'(ejects), 32'd0);
    checkOutput("s3_ready_low", 32'(req_ready), 32'd0);
    tick();
    checkOutput("s3_done_once", 32'(done), 32'd0);
    checkOutput("s3_ready_back", 32'(req_ready), 32'd1);

    $display("[TB] scenario 4: 37 cents faults");
    applyReset();
    applyStimulus(7'd37);
    checkOutput("s4_fault", 32'(fault), 32'd1);
    checkOutput("s4_eject", 32'(ejects), 32'd0);
    checkOutput("s4_ready", 32'(req_ready), 32'd0);
    checkOutput("s4_rem", 32'(remaining), 32'd37);
    req_valid  = 1'b1;
    req_amount = 7'd10;
    tick();
    tick();
    req_valid  = 1'b0;
    req_amount = '0;
    checkOutput("s4_req_ignored", 32'(fault), 32'd1);
    checkOutput("s4_rem_held", 32'(remaining), 32'd37);
    checkOutput("s4_eject_ignored", 32'(ejects), 32'd0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checkOutput("s4_clr_fault", 32'(fault), 32'd0);
    checkOutput("s4_clr_ready", 32'(req_ready), 32'd1);
    checkOutput("s4_clr_rem", 32'(remaining), 32'd0);

    $display("[TB] scenario 5: ack timeout and mid-eject reset");
    applyReset();
    applyStimulus(7'd50);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("s5_wait%0d", i), 32'({ejects, fault}), 32'b1000);
      tick();
    end
    checkOutput("s5_fault", 32'(fault), 32'd1);
    checkOutput("s5_rem", 32'(remaining), 32'd50);
    checkOutput("s5_eject_drop", 32'(ejects), 32'd0);
    checkOutput("s5_busy", 32'(busy), 32'd0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    applyStimulus(7'd50);
    checkOutput("s5_re_eject", 32'(ejects), 32'b100);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s5_rst_eject", 32'(ejects), 32'd0);
    checkOutput("s5_rst_busy", 32'(busy), 32'd0);
    checkOutput("s5_rst_rem", 32'(remaining), 32'd0);
    checkOutput("s5_rst_ready", 32'(req_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("s5_lost_eject", 32'(ejects), 32'd0);
    checkOutput("s5_lost_ready", 32'(req_ready), 32'd1);

`ifdef CHANGE_INVENTORY_EN
    $display("[TB] scenario 6: inventory exhaustion");
    applyReset();
    applyStimulus(7'd50);
    payCoin("s6_q", 3'b100, 7'd25);
    tick();
    payCoin("s6_d", 3'b010, 7'd15);
    tick();
    payCoin("s6_n", 3'b001, 7'd10);
    tick();
    checkOutput("s6_fault", 32'(fault), 32'd1);
    checkOutput("s6_rem", 32'(remaining), 32'd10);
    checkOutput("s6_eject", 32'(ejects), 32'd0);
    checkOutput("s6_inv", 32'(inv_empty), 32'b111);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
